rbf_actfunc_serial_mc: RTL and testbench

//  Multi-channel successor of the serial RBF activation unit. One sample x is applied to CH RBF

---
 rtl/rbf_pkg.sv | 36 +++
 rtl/rbf_region_classify.sv | 67 ++++++
 rtl/rbf_actfunc_serial_mc.sv | 163 ++++++++++++++++
 tb/tb_rbf_actfunc_serial_mc.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rbf_pkg.sv
// rbf_pkg: region/function codes, FSM encoding and shared
// constants for the multi-channel serial RBF activation unit.
package rbf_pkg;

    typedef enum logic [1:0] {
        RG_ZERO   = 2'b00,
        RG_SIDE   = 2'b01,
        RG_CENTRE = 2'b10,
        RG_HIGH   = 2'b11
    } region_e;

    localparam logic [1:0] FT_BELL0 = 2'd0;
    localparam logic [1:0] FT_BELL1 = 2'd1;
    localparam logic [1:0] FT_LEFT  = 2'd2;
    localparam logic [1:0] FT_RIGHT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_XB,
        ST_ABS,
        ST_B1N,
        ST_B1P,
        ST_SEL,
        ST_SQR,
        ST_STREAM
    } state_e;

    // Cycles from region_vld to fbit, identical for all regions.
    localparam int LAT_Y = 1;

    // Width of a per-channel afrac field.
    function automatic int skw(input int n);
        return $clog2(2 * (n + 1));
    endfunction

endpackage

// File: rtl/rbf_region_classify.sv
// rbf_region_classify: XB..B1P intermediate capture for one channel
// and the resulting region / argument / coefficient select.
module rbf_region_classify
    import rbf_pkg::*;
#(
    parameter int N  = 16,
    parameter int bN = 2,
    localparam int W = N + bN + 2
) (
    input  logic                clk,
    input  state_e              st_i,
    input  logic [N-1:0]        x_i,
    input  logic [N+bN-1:0]     b_i,
    input  logic [N+bN-1:0]     b1_i,
    input  logic [N+bN-1:0]     s_i,
    input  logic [1:0]          ft_i,
    output region_e             region_o,
    output logic signed [W-1:0] arg_o,
    output logic                a_sel_o
);

    logic signed [W-1:0] xe, be, b1e, se, ad;
    logic signed [W-1:0] d_q, e_q, dm_q, dp_q;
    logic                sd, hi;

    assign xe  = {{(W-N){x_i[N-1]}}, x_i};
    assign be  = {{2{b_i[N+bN-1]}}, b_i};
    assign b1e = {{2{b1_i[N+bN-1]}}, b1_i};
    assign se  = {{2{s_i[N+bN-1]}}, s_i};
    assign ad  = d_q[W-1] ? -d_q : d_q;

    // One intermediate per sequencer step, shared adder over four cycles.
    always_ff @(posedge clk) begin
        case (st_i)
            ST_XB:   d_q  <= xe - be;
            ST_ABS:  e_q  <= ad - se;
            ST_B1N:  dm_q <= d_q - b1e;
            ST_B1P:  dp_q <= d_q + b1e;
            default: ;
        endcase
    end

    assign sd = d_q[W-1];
    assign hi = (ft_i == FT_LEFT && sd) || (ft_i == FT_RIGHT && !sd);

    // Priority classification; d==0 counts as non-negative.
    always_comb begin
        region_o = RG_ZERO;
        arg_o    = '0;
        a_sel_o  = 1'b0;
        if (hi) begin
            region_o = RG_HIGH;
        end else if (e_q[W-1]) begin
            region_o = RG_CENTRE;
            arg_o    = d_q;
        end else if (!sd && dm_q[W-1]) begin
            region_o = RG_SIDE;
            arg_o    = dm_q;
            a_sel_o  = 1'b1;
        end else if (sd && !dp_q[W-1]) begin
            region_o = RG_SIDE;
            arg_o    = dp_q;
            a_sel_o  = 1'b1;
        end
    end

endmodule

// File: rtl/rbf_actfunc_serial_mc.sv
// rbf_actfunc_serial_mc: one sample through CH RBF neurons in turn,
// shared classifier + multiply/square, LSB-first serial result.
module rbf_actfunc_serial_mc
    import rbf_pkg::*;
#(
    parameter int  N   = 16,
    parameter int  bN  = 2,
    parameter int  CH  = 4,
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1,
    localparam int SKW = skw(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 ready,
    input  logic [N-1:0]         x,
    input  logic [CH*N-1:0]      a0,
    input  logic [CH*N-1:0]      a1,
    input  logic [CH*SKW-1:0]    afrac,
    input  logic [CH*(N+bN)-1:0] b,
    input  logic [CH*(N+bN)-1:0] b1,
    input  logic [CH*(N+bN)-1:0] s,
    input  logic [CH*N-1:0]      w,
    input  logic [CH*2-1:0]      func_type,
    output logic [1:0]           region,
    output logic                 region_vld,
    output logic [CHW-1:0]       ch_id,
    output logic                 y,
    output logic                 fbit,
    output logic                 done
);

    localparam int W  = N + bN + 2;
    localparam int PW = N + W;
    localparam int QW = 2 * N - 1;
    localparam int BW = $clog2(N);
    localparam int CW = N + bN;

    state_e         state_q, state_d;
    logic [CHW-1:0] ch_q;
    logic [BW-1:0]  bit_q;
    logic [N-1:0]   x_q, sh_q, sq_n, res;
    logic [QW-1:0]  p_q, sq;
    region_e        region_q, cls_rg;
    logic           rv_q, cls_asel, last_bit, last_ch;

    logic signed [W-1:0]  cls_arg;
    logic [N-1:0]         a_c;
    logic signed [PW-1:0] a_x, arg_x, prod;

    logic [N-1:0]   a0_a [CH];
    logic [N-1:0]   a1_a [CH];
    logic [N-1:0]   w_a  [CH];
    logic [SKW-1:0] af_a [CH];
    logic [CW-1:0]  b_a  [CH];
    logic [CW-1:0]  b1_a [CH];
    logic [CW-1:0]  s_a  [CH];
    logic [1:0]     ft_a [CH];

    for (genvar k = 0; k < CH; k++) begin : g_ch
        assign a0_a[k] = a0[k*N +: N];
        assign a1_a[k] = a1[k*N +: N];
        assign w_a[k]  = w[k*N +: N];
        assign af_a[k] = afrac[k*SKW +: SKW];
        assign b_a[k]  = b[k*CW +: CW];
        assign b1_a[k] = b1[k*CW +: CW];
        assign s_a[k]  = s[k*CW +: CW];
        assign ft_a[k] = func_type[k*2 +: 2];
    end

    rbf_region_classify #(.N(N), .bN(bN)) u_cls (
        .clk      (clk),
        .st_i     (state_q),
        .x_i      (x_q),
        .b_i      (b_a[ch_q]),
        .b1_i     (b1_a[ch_q]),
        .s_i      (s_a[ch_q]),
        .ft_i     (ft_a[ch_q]),
        .region_o (cls_rg),
        .arg_o    (cls_arg),
        .a_sel_o  (cls_asel)
    );

    assign a_c   = cls_asel ? a1_a[ch_q] : a0_a[ch_q];
    assign a_x   = {{W{a_c[N-1]}}, a_c};
    assign arg_x = {{N{cls_arg[W-1]}}, cls_arg};
    assign prod  = a_x * arg_x;

    // Only the low 2N-1 bits of p matter for the square's kept bits.
    assign sq   = p_q * p_q;
    assign sq_n = N'(sq >> (N - 1));

    assign last_bit = (bit_q == BW'(N - 1));
    assign last_ch  = (ch_q == CHW'(CH - 1));

    // Region-dependent result word for the streamer.
    always_comb begin
        res = '0;
        unique case (region_q)
            RG_CENTRE: res = w_a[ch_q] - sq_n;
            RG_SIDE:   res = sq_n;
            RG_HIGH:   res = w_a[ch_q];
            RG_ZERO:   res = '0;
        endcase
    end

    // Next-state: per-channel sequence, loop back until last channel.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start) state_d = ST_XB;
            ST_XB:     state_d = ST_ABS;
            ST_ABS:    state_d = ST_B1N;
            ST_B1N:    state_d = ST_B1P;
            ST_B1P:    state_d = ST_SEL;
            ST_SEL:    state_d = ST_SQR;
            ST_SQR:    state_d = ST_STREAM;
            ST_STREAM: if (last_bit) state_d = last_ch ? ST_IDLE : ST_XB;
        endcase
    end

    // Control state: FSM, channel/bit counters, region strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ch_q     <= '0;
            bit_q    <= '0;
            region_q <= RG_ZERO;
            rv_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            rv_q    <= (state_q == ST_SEL);
            if (state_q == ST_SEL) region_q <= cls_rg;
            if (state_q == ST_IDLE && start)
                ch_q <= '0;
            else if (state_q == ST_STREAM && last_bit && !last_ch)
                ch_q <= ch_q + 1'b1;
            if (state_q == ST_SQR)
                bit_q <= '0;
            else if (state_q == ST_STREAM)
                bit_q <= bit_q + 1'b1;
        end
    end

    // Datapath registers: sample latch, scaled product, shift-out word.
    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && start) x_q <= x;
        if (state_q == ST_SEL) p_q <= QW'(prod >>> af_a[ch_q]);
        if (state_q == ST_SQR)
            sh_q <= res;
        else if (state_q == ST_STREAM)
            sh_q <= sh_q >> 1;
    end

    assign ready      = (state_q == ST_IDLE);
    assign region     = region_q;
    assign region_vld = rv_q;
    assign ch_id      = ch_q;
    assign y          = (state_q == ST_STREAM) && sh_q[0];
    assign fbit       = (state_q == ST_STREAM) && (bit_q == '0);
    assign done       = (state_q == ST_STREAM) && last_bit && last_ch;

endmodule

// File: tb/tb_rbf_actfunc_serial_mc.sv
// tb_rbf_actfunc_serial_mc: table of 4-channel samples with hand-computed
// region/result per channel, plus start-hold and mid-stream reset runs.
module tb_rbf_actfunc_serial_mc;
    import rbf_pkg::*;

    localparam int N   = 16;
    localparam int BN  = 2;
    localparam int CH  = 4;
    localparam int CHW = 2;
    localparam int SKW = 6;
    localparam int P   = 5 + LAT_Y + N;
    localparam int T   = CH * P + 3;

    logic                 clk = 1'b0;
    logic                 rst, start;
    logic [N-1:0]         x;
    logic [CH*N-1:0]      a0, a1, w;
    logic [CH*SKW-1:0]    afrac;
    logic [CH*(N+BN)-1:0] b, b1, s;
    logic [CH*2-1:0]      func_type;
    logic                 ready, region_vld, y, fbit, done;
    logic [1:0]           region;
    logic [CHW-1:0]       ch_id;

    always #5 clk = ~clk;

    rbf_actfunc_serial_mc #(.N(N), .bN(BN), .CH(CH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ready      (ready),
        .x          (x),
        .a0         (a0),
        .a1         (a1),
        .afrac      (afrac),
        .b          (b),
        .b1         (b1),
        .s          (s),
        .w          (w),
        .func_type  (func_type),
        .region     (region),
        .region_vld (region_vld),
        .ch_id      (ch_id),
        .y          (y),
        .fbit       (fbit),
        .done       (done)
    );

    typedef struct {
        logic [N-1:0]             x;
        logic [CH-1:0][N+BN-1:0]  b;
        logic [CH-1:0][N+BN-1:0]  b1;
        logic [CH-1:0][N+BN-1:0]  s;
        logic [CH-1:0][N-1:0]     w;
        logic [CH-1:0][1:0]       ft;
        logic [CH-1:0][1:0]       rg;
        logic [CH-1:0][N-1:0]     yv;
    } vec_t;

    vec_t vecs [3];
    int   checks = 0;
    int   passed = 0;

    logic           tr_rdy [T];
    logic           tr_rv  [T];
    logic           tr_fb  [T];
    logic           tr_y   [T];
    logic           tr_dn  [T];
    logic [1:0]     tr_rg  [T];
    logic [CHW-1:0] tr_ch  [T];

    task automatic check(input string name, input int act, input int exp,
                         input int tol);
        int d;
        d = act - exp;
        checks++;
        if (d >= -tol && d <= tol) passed++;
        else $display("FAIL %s: got %0h expected %0h (tol %0d)",
                      name, act, exp, tol);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " ready"},      int'(ready),      1, 0);
        check({tag, " region"},     int'(region),     0, 0);
        check({tag, " region_vld"}, int'(region_vld), 0, 0);
        check({tag, " ch_id"},      int'(ch_id),      0, 0);
        check({tag, " y"},          int'(y),          0, 0);
        check({tag, " fbit"},       int'(fbit),       0, 0);
        check({tag, " done"},       int'(done),       0, 0);
    endtask

    task automatic apply(input vec_t v);
        x         = v.x;
        b         = v.b;
        b1        = v.b1;
        s         = v.s;
        w         = v.w;
        func_type = v.ft;
    endtask

    task automatic run_sample(input int vi, input bit hold);
        vec_t         v;
        int           nrv, nfb, ndn, busy_rdy, idle_nrdy, rc, fc, tol;
        logic [N-1:0] yv;
        string        t;
        v = vecs[vi];
        apply(v);
        @(negedge clk);
        t = $sformatf("v%0d%s", vi, hold ? "h" : "");
        check({t, " ready_before"}, int'(ready), 1, 0);
        start = 1'b1;
        for (int c = 0; c < T; c++) begin
            @(negedge clk);
            tr_rdy[c] = ready;
            tr_rv[c]  = region_vld;
            tr_fb[c]  = fbit;
            tr_y[c]   = y;
            tr_dn[c]  = done;
            tr_rg[c]  = region;
            tr_ch[c]  = ch_id;
            start     = hold && (c < CH * P);
        end
        start = 1'b0;
        nrv = 0; nfb = 0; ndn = 0; busy_rdy = 0; idle_nrdy = 0;
        for (int c = 0; c < T; c++) begin
            nrv += int'(tr_rv[c]);
            nfb += int'(tr_fb[c]);
            ndn += int'(tr_dn[c]);
            if (c < CH * P) busy_rdy += int'(tr_rdy[c]);
            else idle_nrdy += int'(!tr_rdy[c]);
        end
        for (int k = 0; k < CH; k++) begin
            rc = k * P + 5;
            fc = rc + LAT_Y;
            check($sformatf("%s ch%0d region_vld", t, k), int'(tr_rv[rc]), 1, 0);
            check($sformatf("%s ch%0d rv_ch_id", t, k), int'(tr_ch[rc]), k, 0);
            check($sformatf("%s ch%0d region", t, k), int'(tr_rg[rc]),
                  int'(v.rg[k]), 0);
            check($sformatf("%s ch%0d fbit", t, k), int'(tr_fb[fc]), 1, 0);
            check($sformatf("%s ch%0d fb_ch_id", t, k), int'(tr_ch[fc]), k, 0);
            for (int i = 0; i < N; i++) yv[i] = tr_y[fc + i];
            tol = (v.rg[k] == 2'b01 || v.rg[k] == 2'b10) ? 1 : 0;
            check($sformatf("%s ch%0d y", t, k), int'(yv), int'(v.yv[k]), tol);
        end
        check({t, " n_region_vld"}, nrv, CH, 0);
        check({t, " n_fbit"}, nfb, CH, 0);
        check({t, " n_done"}, ndn, 1, 0);
        check({t, " done_pos"}, int'(tr_dn[CH * P - 1]), 1, 0);
        check({t, " ready_busy"}, busy_rdy, 0, 0);
        check({t, " ready_back"}, idle_nrdy, 0, 0);
    endtask

    task automatic reset_mid();
        int n;
        apply(vecs[1]);
        @(negedge clk);
        start = 1'b1;
        for (int c = 0; c < P + 10; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("mid pre_rst ch_id", int'(ch_id), 1, 0);
        check("mid pre_rst region", int'(region), 3, 0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        rst = 1'b0;
        n = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            n += int'(region_vld) + int'(fbit) + int'(done);
        end
        check("mid quiet_after_rst", n, 0, 0);
    endtask

    initial begin
        vecs[0].x  = 16'h0000;
        vecs[0].b  = {18'h04000, 18'h3C000, 18'h38CCD, 18'h00000};
        vecs[0].b1 = {18'h06000, 18'h06000, 18'h04000, 18'h06000};
        vecs[0].s  = {18'h02000, 18'h02000, 18'h02000, 18'h02000};
        vecs[0].w  = {16'h3000, 16'h5000, 16'h1111, 16'h4000};
        vecs[0].ft = {2'd0, 2'd3, 2'd0, 2'd0};
        vecs[0].rg = {2'b01, 2'b11, 2'b00, 2'b10};
        vecs[0].yv = {16'h0800, 16'h5000, 16'h0000, 16'h4000};

        vecs[1].x  = 16'h4000;
        vecs[1].b  = {18'h02000, 18'h04000, 18'h04000, 18'h00000};
        vecs[1].b1 = {18'h06000, 18'h01000, 18'h06000, 18'h06000};
        vecs[1].s  = {18'h04000, 18'h00000, 18'h02000, 18'h02000};
        vecs[1].w  = {16'h4000, 16'h7777, 16'h1234, 16'h5000};
        vecs[1].ft = {2'd0, 2'd2, 2'd3, 2'd2};
        vecs[1].rg = {2'b10, 2'b01, 2'b11, 2'b01};
        vecs[1].yv = {16'h3800, 16'h0200, 16'h1234, 16'h0800};

        vecs[2].x  = 16'h8000;
        vecs[2].b  = {18'h00000, 18'h38000, 18'h00000, 18'h00000};
        vecs[2].b1 = {18'h08000, 18'h04000, 18'h04000, 18'h04000};
        vecs[2].s  = {18'h07FFF, 18'h00001, 18'h02000, 18'h02000};
        vecs[2].w  = {16'h2222, 16'h7FFF, 16'h1111, 16'h8000};
        vecs[2].ft = {2'd1, 2'd0, 2'd0, 2'd2};
        vecs[2].rg = {2'b01, 2'b10, 2'b00, 2'b11};
        vecs[2].yv = {16'h0000, 16'h7FFF, 16'h0000, 16'h8000};

        rst   = 1'b1;
        start = 1'b0;
        a0    = {CH{16'h7FFF}};
        a1    = {CH{16'h7FFF}};
        afrac = {CH{6'd15}};
        apply(vecs[0]);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;

        for (int i = 0; i < 3; i++) run_sample(i, 1'b0);
        run_sample(1, 1'b1);
        reset_mid();
        run_sample(2, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
